// File: rtl/p_encoder_iter_if.sv
// Handshake bundle for p_encoder_iter: mask input stream and index output stream.
// Macro P_ENC_ITER_REMAIN_EN adds the out_remain beat counter to the bundle.
interface p_encoder_iter_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_zero;
`ifdef P_ENC_ITER_REMAIN_EN
    logic [IDX_W:0]   out_remain;
`endif

    modport master (
        output in_valid, in_mask, out_ready,
`ifdef P_ENC_ITER_REMAIN_EN
        input  out_remain,
`endif
        input  in_ready, out_valid, out_idx, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_mask, out_ready,
`ifdef P_ENC_ITER_REMAIN_EN
        output out_remain,
`endif
        output in_ready, out_valid, out_idx, out_last, out_zero
    );
endinterface

// File: rtl/p_encoder_iter.sv
// Iterative leading-one encoder: emits every set bit of a mask, MSB first, one beat per cycle.
// Macro P_ENC_ITER_REMAIN_EN adds a registered count of beats remaining (out_remain).
module p_encoder_iter #(
    parameter int unsigned WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    p_encoder_iter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic             zflag_q;

    logic [WIDTH-1:0] lead_oh;
    logic [IDX_W-1:0] lead_idx;
    logic             single_bit;
    logic             busy;
    logic             last_int;
    logic             consume;
    logic             ready_int;
    logic             accept;

    // Ascending scan so the highest set bit wins.
    always_comb begin
        lead_oh  = '0;
        lead_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (work_q[i]) begin
                lead_oh    = '0;
                lead_oh[i] = 1'b1;
                lead_idx   = IDX_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

    assign single_bit = (work_q != '0) && ((work_q & (work_q - WIDTH'(1))) == '0);
    assign busy       = (state_q == StBusy);
    assign last_int   = zflag_q || single_bit;
    assign consume    = busy && bus.out_ready;
    assign ready_int  = !busy || (consume && last_int);
    assign accept     = bus.in_valid && ready_int;

    assign bus.in_ready  = ready_int;
    assign bus.out_valid = busy;
    assign bus.out_idx   = busy ? lead_idx : '0;
    assign bus.out_last  = busy && last_int;
    assign bus.out_zero  = busy && zflag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            work_q  <= '0;
            zflag_q <= 1'b0;
        end else if (accept) begin
            state_q <= StBusy;
            work_q  <= bus.in_mask;
            zflag_q <= (bus.in_mask == '0);
        end else if (consume) begin
            work_q <= work_q & ~lead_oh;
            if (last_int) begin
                state_q <= StIdle;
                zflag_q <= 1'b0;
            end
        end
    end

`ifdef P_ENC_ITER_REMAIN_EN
    logic [IDX_W:0] remain_q;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] m);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, m[i]};
        end
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remain_q <= '0;
        end else if (accept) begin
            remain_q <= popcount(bus.in_mask);
        end else if (consume) begin
            // A zero mask carries a count of 0; do not wrap it on its single beat.
            remain_q <= last_int ? '0 : remain_q - (IDX_W + 1)'(1);
        end
    end

    assign bus.out_remain = busy ? remain_q : '0;
`endif

endmodule

// File: doc/p_encoder_iter.md
Name: p_encoder_iter

Overview:
- Parametrised sequential successor to the 16-to-4 leading-one encoder.
- Accepts a WIDTH-bit sparse bitmask over a valid/ready handshake.
- Emits the position of every set bit, one per cycle, from MSB to LSB, clearing each bit as it is consumed.
- Feeds bit-serial PE schedulers that process only the non-zero bits of an operand.

Parameters:
- WIDTH, 16, mask width; power of two, at least 2.
- IDX_W, $clog2(WIDTH), index width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block can accept a mask this cycle.
- in_mask  input  WIDTH  bitmask; bit WIDTH-1 has the highest priority.
- out_valid  output  1  out_idx, out_last and out_zero are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IDX_W  leading-one position, counted from the MSB (bit WIDTH-1 -> 0, bit 0 -> WIDTH-1).
- out_last  output  1  current beat is the final beat for this mask.
- out_zero  output  1  accepted mask was all zeros.

Behaviour:
- State register: IDLE / BUSY. Working mask register: work[WIDTH-1:0]. Zero flag register: zflag.
- Reset asserted (reset=0), asynchronous:
  - state=IDLE, work=0, zflag=0.
  - out_valid=0, out_idx=0, out_last=0, out_zero=0.
  - in_ready=1 once state is IDLE.
- in_ready is combinational: (state==IDLE) || (out_valid && out_ready && out_last).
- Accept: on a rising edge with in_valid && in_ready:
  - work <= in_mask; zflag <= (in_mask==0); state <= BUSY.
- Latency: a mask accepted at edge N gives out_valid=1 in the cycle after edge N.
- BUSY outputs are driven combinationally from registers only; in_mask never reaches them:
  - out_valid=1.
  - out_idx = MSB-relative position of the highest set bit of work; 0 if work==0.
  - out_last = zflag || (work has exactly one bit set).
  - out_zero = zflag.
- Beat consumed (out_valid && out_ready):
  - Clear the bit at out_idx in work.
  - If out_last: state <= IDLE, unless a new mask is accepted on the same edge, in which case state stays BUSY with the new mask loaded. This gives back-to-back masks with no bubble.
- Backpressure (out_ready=0): work, out_idx, out_last and out_zero hold stable; no bit is cleared.
- All-zero mask: exactly one beat with out_zero=1, out_idx=0, out_last=1.
- In IDLE, out_valid=0 and out_idx, out_last, out_zero are driven to 0.
- in_valid while BUSY and not on the last beat: not accepted; the producer holds in_mask.
- Reset mid-stream: the current mask is discarded with no partial completion. The first cycle after reset release is IDLE.
- Throughput: popcount(mask) cycles per non-zero mask, 1 cycle per zero mask.
- The leading-one search is a parametrised loop or tree, not a hard-coded casez.

Optional Feature:
- Macro: P_ENC_ITER_REMAIN_EN.
- Defined:
  - Adds output port out_remain, width IDX_W+1: the number of set bits in work, including the current beat, while BUSY.
  - out_remain is 0 in IDLE and 0 for a zero mask.
  - out_remain decrements by 1 per consumed beat; it is registered and loaded with popcount(in_mask) on accept.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset low mid-stream with WIDTH=16, mask 16'hFFFF, after 3 beats -> out_valid=0 immediately; after release in_ready=1; the next mask 16'h0001 yields a single beat with idx=15, last=1.
- Mask 16'h8001, out_ready=1 -> beat idx=0 last=0, then beat idx=15 last=1, then out_valid=0.
- Mask 16'h0000 -> single beat with out_zero=1, out_idx=0, out_last=1; in_ready=1 during that beat.
- Mask 16'h0410 with out_ready low for 3 cycles -> out_idx holds 5 for all 3 cycles; after out_ready=1, idx=5 then idx=11 last=1.
- Back-to-back masks 16'h0100 then 16'h0003, in_valid continuously high -> idx 7 (last); the second mask is accepted on that edge; then idx 14, idx 15 (last) on consecutive cycles with no gap.
- WIDTH=32, mask 32'h0000_0100 -> idx=23, last=1; with P_ENC_ITER_REMAIN_EN and mask 32'hF000_0000 -> out_remain sequence 4,3,2,1.
